// File: rtl/sample_capture.sv
// sample_capture: acquisition front end for the spectrum analyzer.
// A one-cycle start pulse captures NUM_SAMPLES conversions from a serial ADC
// (16-bit SPI frames, MSB first) and writes the low SAMPLE_W bits of each
// frame into the FFT input buffer at consecutive addresses. done pulses
// once at the end of the frame.
//
// Build option: define SAMPLE_SIGNED_EN to write samples with their MSB
// inverted (offset binary -> two's complement centred on mid-scale).
// Without it the raw unsigned ADC code is written.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; sample index and bit counter cleared
// CONVERT | adc_cs_n low, 16 SCLK periods, serial data shifted in
// WRITE   | one-cycle buffer write of the captured sample
// GAP     | adc_cs_n high for GAP_CYCLES between conversions
// DONE    | one-cycle done pulse, busy low, then back to IDLE

module sample_capture #(
  parameter int NUM_SAMPLES = 256,
  parameter int ADDR_W      = 8,
  parameter int SAMPLE_W    = 12,
  parameter int SCLK_DIV    = 4,
  parameter int GAP_CYCLES  = 4
) (
  input  logic                Clk,
  input  logic                reset,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                adc_cs_n,
  output logic                adc_sclk,
  input  logic                adc_sdata,
  output logic                wr_en,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [SAMPLE_W-1:0] wr_data
);

  localparam int FRAME_BITS = 16;
  localparam int HALF_W     = 5;
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(2 * FRAME_BITS - 1);
  localparam int CNT_MAX    = (SCLK_DIV > GAP_CYCLES) ? SCLK_DIV : GAP_CYCLES;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0]  DIV_LOAD  = CNT_W'(SCLK_DIV - 1);
  localparam logic [CNT_W-1:0]  GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [ADDR_W-1:0] IDX_LAST  = ADDR_W'(NUM_SAMPLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONVERT,
    S_WRITE,
    S_GAP,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  // Shared down-counter: SCLK half-period timer in CONVERT, gap timer in GAP.
  logic [CNT_W-1:0]      tmr_cnt;
  logic [HALF_W-1:0]     half_cnt;
  logic [ADDR_W-1:0]     idx;
  logic [FRAME_BITS-1:0] shift;
  logic                  sdata_s1;
  logic                  sdata_s2;

  logic tmr_tc;
  logic half_last;
  logic idx_last;
  logic sclk_rise;

  logic                busy_nxt;
  logic                done_nxt;
  logic                cs_n_nxt;
  logic                sclk_nxt;
  logic                wr_en_nxt;
  logic [SAMPLE_W-1:0] sample_fmt;

  // The top frame bits carry leading zeros from the ADC and are dropped.
  logic unused_frame_bits;
  assign unused_frame_bits = ^shift[FRAME_BITS-1:SAMPLE_W];

  assign tmr_tc    = (tmr_cnt == '0);
  assign half_last = (half_cnt == HALF_LAST);
  assign idx_last  = (idx == IDX_LAST);
  // Even half-periods are SCLK low; leaving one drives SCLK high.
  assign sclk_rise = (state == S_CONVERT) && tmr_tc && !half_cnt[0];

`ifdef SAMPLE_SIGNED_EN
  assign sample_fmt = {~shift[SAMPLE_W-1], shift[SAMPLE_W-2:0]};
`else
  assign sample_fmt = shift[SAMPLE_W-1:0];
`endif

  // State register.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_CONVERT;
      end
      S_CONVERT: begin
        if (tmr_tc && half_last) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        state_nxt = idx_last ? S_DONE : S_GAP;
      end
      S_GAP: begin
        if (tmr_tc) state_nxt = S_CONVERT;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Next values of the registered outputs, decoded from the next state so
  // every output changes on the same edge as the state it belongs to.
  always_comb begin
    busy_nxt  = 1'b0;
    done_nxt  = 1'b0;
    cs_n_nxt  = 1'b1;
    sclk_nxt  = 1'b1;
    wr_en_nxt = 1'b0;
    case (state_nxt)
      S_CONVERT: begin
        busy_nxt = 1'b1;
        cs_n_nxt = 1'b0;
        if (state != S_CONVERT) begin
          sclk_nxt = 1'b0;
        end else if (tmr_tc) begin
          sclk_nxt = ~half_cnt[0];
        end else begin
          sclk_nxt = half_cnt[0];
        end
      end
      S_WRITE: begin
        busy_nxt  = 1'b1;
        cs_n_nxt  = 1'b0;
        wr_en_nxt = 1'b1;
      end
      S_GAP: begin
        busy_nxt = 1'b1;
      end
      S_DONE: begin
        done_nxt = 1'b1;
      end
      default: begin
        busy_nxt = 1'b0;
      end
    endcase
  end

  // Two-flop synchronizer for the ADC serial data.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      sdata_s1 <= 1'b0;
      sdata_s2 <= 1'b0;
    end else begin
      sdata_s1 <= adc_sdata;
      sdata_s2 <= sdata_s1;
    end
  end

  // Timer, half-period counter, sample index and shift register.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      tmr_cnt  <= '0;
      half_cnt <= '0;
      idx      <= '0;
      shift    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          tmr_cnt  <= DIV_LOAD;
          half_cnt <= '0;
          idx      <= '0;
        end
        S_CONVERT: begin
          if (tmr_tc) begin
            tmr_cnt  <= DIV_LOAD;
            half_cnt <= half_cnt + HALF_W'(1);
          end else begin
            tmr_cnt <= tmr_cnt - CNT_W'(1);
          end
          // Synchronizer latency is absorbed here: the bit taken is the one
          // present on adc_sdata two Clk cycles before the SCLK rising edge.
          if (sclk_rise) begin
            shift <= {shift[FRAME_BITS-2:0], sdata_s2};
          end
        end
        S_WRITE: begin
          tmr_cnt <= GAP_LOAD;
          if (!idx_last) idx <= idx + ADDR_W'(1);
        end
        S_GAP: begin
          if (tmr_tc) begin
            tmr_cnt  <= DIV_LOAD;
            half_cnt <= '0;
          end else begin
            tmr_cnt <= tmr_cnt - CNT_W'(1);
          end
        end
        default: begin
          half_cnt <= '0;
        end
      endcase
    end
  end

  // Output registers; write address/data hold between writes.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      adc_cs_n <= 1'b1;
      adc_sclk <= 1'b1;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      busy     <= busy_nxt;
      done     <= done_nxt;
      adc_cs_n <= cs_n_nxt;
      adc_sclk <= sclk_nxt;
      wr_en    <= wr_en_nxt;
      if (state_nxt == S_WRITE) begin
        wr_addr <= idx;
        wr_data <= sample_fmt;
      end
    end
  end

endmodule

// File: tb/tb_sample_capture.sv
// Bench for sample_capture: 4-sample frames at SCLK_DIV=2, GAP_CYCLES=2.
// A serial ADC model supplies fixed words; expected buffer writes go into a
// queue that a write monitor drains. A second monitor checks the SPI shape.

module tb_sample_capture;

  localparam int NS  = 4;
  localparam int AW  = 2;
  localparam int SW  = 12;
  localparam int DIV = 2;
  localparam int GAP = 2;
  localparam int FRAME_CYC = 266;

  localparam logic [15:0] WORDS [NS] = '{16'h0ABC, 16'h0001, 16'h0FFF, 16'h0800};
`ifdef SAMPLE_SIGNED_EN
  localparam logic [SW-1:0] EXP_DATA [NS] = '{12'h2BC, 12'h801, 12'h7FF, 12'h000};
`else
  localparam logic [SW-1:0] EXP_DATA [NS] = '{12'hABC, 12'h001, 12'hFFF, 12'h800};
`endif

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [SW-1:0] data;
  } wr_t;

  logic          Clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          adc_sdata = 1'b0;
  logic          busy, done, adc_cs_n, adc_sclk, wr_en;
  logic [AW-1:0] wr_addr;
  logic [SW-1:0] wr_data;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  wr_t exp_q[$];

  sample_capture #(
    .NUM_SAMPLES(NS),
    .ADDR_W(AW),
    .SAMPLE_W(SW),
    .SCLK_DIV(DIV),
    .GAP_CYCLES(GAP)
  ) dut (
    .Clk(Clk),
    .reset(reset),
    .start(start),
    .busy(busy),
    .done(done),
    .adc_cs_n(adc_cs_n),
    .adc_sclk(adc_sclk),
    .adc_sdata(adc_sdata),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // ADC model: presents the MSB while idle, advances one bit after each SCLK rise.
  int mb = 0;
  int mw = 0;
  logic prev_sclk = 1'b1;
  logic [15:0] cur_word;
  always @(posedge Clk) begin
    #1;
    if (!reset) begin
      mb = 0;
      mw = 0;
    end else if (adc_sclk && !prev_sclk) begin
      mb++;
      if (mb == 16) begin
        mb = 0;
        mw = (mw + 1) % NS;
      end
    end
    prev_sclk = adc_sclk;
    cur_word = WORDS[mw];
    adc_sdata = cur_word[15-mb];
  end

  // Write monitor: pops the scoreboard on every buffer write.
  always @(negedge Clk) begin
    if (wr_en) begin
      wr_t e;
      wr_cnt++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL wr_unexpected: actual addr=0x%0h data=0x%0h required no write", wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(wr_addr), 32'(e.addr));
        chk("wr_data", 32'(wr_data), 32'(e.data));
      end
    end
    if (done) done_cnt++;
  end

  // SPI shape monitor.
  int rises = 0;
  int run = 0;
  int gap_len = 100;
  logic pcs = 1'b1;
  logic psclk = 1'b1;
  always @(negedge Clk) begin
    if (!reset) begin
      rises = 0;
      run = 0;
      gap_len = 100;
      pcs = 1'b1;
      psclk = 1'b1;
    end else begin
      if (!adc_cs_n) begin
        if (pcs) begin
          chk("cs_gap_min", 32'(gap_len >= 2), 32'd1);
          rises = 0;
          run = 1;
        end else if (adc_sclk == psclk) begin
          run++;
        end else begin
          chk("sclk_half_width", 32'(run), 32'(DIV));
          run = 1;
          if (adc_sclk) rises++;
        end
      end else begin
        if (!pcs) begin
          chk("sclk_rises", 32'(rises), 32'd16);
          gap_len = 0;
        end
        gap_len++;
      end
      pcs = adc_cs_n;
      psclk = adc_sclk;
    end
  end

  task automatic push_frame();
    for (int i = 0; i < NS; i++) begin
      wr_t e;
      e.addr = AW'(i);
      e.data = EXP_DATA[i];
      exp_q.push_back(e);
    end
  endtask

  task automatic launch(output int e0);
    @(posedge Clk);
    #2 start = 1'b1;
    @(posedge Clk);
    #2 start = 1'b0;
    @(negedge Clk);
    e0 = cyc;
    chk("busy_after_e0", 32'(busy), 32'd1);
    chk("cs_n_after_e0", 32'(adc_cs_n), 32'd0);
    chk("sclk_after_e0", 32'(adc_sclk), 32'd0);
  endtask

  task automatic wait_done(input int e0, input bit poke);
    bit found = 1'b0;
    for (int i = 0; i < FRAME_CYC + 50; i++) begin
      @(negedge Clk);
      if (done) begin
        found = 1'b1;
        break;
      end
    end
    chk("done_seen", 32'(found), 32'd1);
    if (found) begin
      chk("done_cycle", 32'(cyc - e0), 32'(FRAME_CYC));
      chk("busy_at_done", 32'(busy), 32'd0);
      if (poke) start = 1'b1;
      @(posedge Clk);
      #2 start = 1'b0;
    end
  endtask

  task automatic check_quiet(input string name, input int n);
    int act = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      if (busy || done || !adc_cs_n || !adc_sclk || wr_en) act++;
    end
    chk(name, 32'(act), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e0;
    int wr0;
    int d0;
    #3 reset = 1'b0;
    repeat (3) @(negedge Clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cs_n", 32'(adc_cs_n), 32'd1);
    chk("rst_sclk", 32'(adc_sclk), 32'd1);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    @(posedge Clk);
    #2 reset = 1'b1;
    check_quiet("idle_after_reset", 10);

    // Basic frame, with start pulses at E0+10 and in the DONE cycle.
    wr0 = wr_cnt;
    d0 = done_cnt;
    push_frame();
    launch(e0);
    repeat (9) @(posedge Clk);
    #2 start = 1'b1;
    @(posedge Clk);
    #2 start = 1'b0;
    wait_done(e0, 1'b1);
    check_quiet("no_restart_after_done", 20);
    chk("frame1_writes", 32'(wr_cnt - wr0), 32'd4);
    chk("frame1_dones", 32'(done_cnt - d0), 32'd1);
    chk("frame1_queue_empty", 32'(exp_q.size()), 32'd0);

    // Abort during sample 1 conversion.
    wr0 = wr_cnt;
    d0 = done_cnt;
    push_frame();
    launch(e0);
    repeat (100) @(posedge Clk);
    #2 reset = 1'b0;
    @(negedge Clk);
    chk("abort_cs_n", 32'(adc_cs_n), 32'd1);
    chk("abort_sclk", 32'(adc_sclk), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_wr_en", 32'(wr_en), 32'd0);
    chk("abort_wr_addr", 32'(wr_addr), 32'd0);
    chk("abort_pending", 32'(exp_q.size()), 32'd3);
    exp_q.delete();
    repeat (5) @(negedge Clk);
    @(posedge Clk);
    #2 reset = 1'b1;
    check_quiet("idle_after_abort", 10);
    chk("abort_writes", 32'(wr_cnt - wr0), 32'd1);
    chk("abort_dones", 32'(done_cnt - d0), 32'd0);

    // Restart: full frame from address 0.
    wr0 = wr_cnt;
    d0 = done_cnt;
    push_frame();
    launch(e0);
    wait_done(e0, 1'b0);
    check_quiet("idle_after_restart", 5);
    chk("frame2_writes", 32'(wr_cnt - wr0), 32'd4);
    chk("frame2_dones", 32'(done_cnt - d0), 32'd1);
    chk("frame2_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
